// File: rtl/udp_ts_pkg.sv
// rtl/udp_ts_pkg.sv - shared TS constants, parameter-word layout and DMA state encoding
package udp_ts_pkg;

   localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
   localparam int         TS_LEN_188   = 188;
   localparam int         P_TS_WORDS   = TS_LEN_188 / 4;

   localparam int PARAM_CH_MSB  = 31;
   localparam int PARAM_CH_LSB  = 16;
   localparam int PARAM_PID_MSB = 12;
   localparam int PARAM_PID_LSB = 0;

   typedef enum logic [2:0] {
      S_ALLOC,
      S_WAIT_SOP,
      S_DATA,
      S_PARAM,
      S_POST
   } dma_state_t;

   function automatic logic [31:0] pack_param(input logic [15:0] channel, input logic [12:0] pid);
      logic [31:0] word;
      word = '0;
      word[PARAM_CH_MSB:PARAM_CH_LSB]   = channel;
      word[PARAM_PID_MSB:PARAM_PID_LSB] = pid;
      return word;
   endfunction

endpackage

// File: rtl/udp_ts_rx_dma.sv
// rtl/udp_ts_rx_dma.sv - TS receive DMA: payload stream into frame-buffer entry, then post pointer
// Optional RX_SYNC_CHECK_EN: drop packets whose first data word lacks the 0x47 sync byte.
module udp_ts_rx_dma #(
   parameter int P_POINTER_WIDTH         = 2,
   parameter int P_BUFFER_PARAMETER_WORD = 50,
   parameter int P_BUFFER_ADDRESS_BITS   = 8,
   parameter int P_TS_WORDS              = udp_ts_pkg::P_TS_WORDS
) (
   input  logic                             payload_clk,
   input  logic                             payload_rst_n,
   output logic                             alloc_req,
   input  logic                             alloc_ack,
   input  logic [P_POINTER_WIDTH-1:0]       alloc_pointer,
   output logic                             payload_in_ready,
   input  logic                             payload_in_valid,
   input  logic                             payload_in_start,
   input  logic                             payload_in_end,
   input  logic [31:0]                      payload_in_data,
   output logic                             buffer_write,
   output logic [P_POINTER_WIDTH-1:0]       buffer_pointer,
   output logic [P_BUFFER_ADDRESS_BITS-1:0] buffer_address,
   output logic [31:0]                      buffer_writedata,
   output logic                             post_req,
   output logic [P_POINTER_WIDTH-1:0]       post_pointer,
   input  logic                             post_ack,
   output logic [15:0]                      drop_count
);
   import udp_ts_pkg::*;

   localparam logic [5:0] LAST_COUNT = 6'(P_TS_WORDS - 1);
   localparam logic [P_BUFFER_ADDRESS_BITS-1:0] PARAM_ADDR =
      P_BUFFER_ADDRESS_BITS'(P_BUFFER_PARAMETER_WORD);

   dma_state_t  state, next_state;
   logic [5:0]  count;
   logic [15:0] channel;
   logic [12:0] pid;
   logic        accept;
   logic        sync_bad;
   logic        take_pointer;
   logic        latch_channel;
   logic        data_write;
   logic        drop;

   assign accept = payload_in_valid & payload_in_ready;

`ifdef RX_SYNC_CHECK_EN
   assign sync_bad = (count == 6'd0) && (payload_in_data[31:24] != TS_SYNC_BYTE);
`else
   assign sync_bad = 1'b0;
`endif

   always_comb begin
      next_state       = state;
      take_pointer     = 1'b0;
      latch_channel    = 1'b0;
      data_write       = 1'b0;
      drop             = 1'b0;
      // alloc_req is masked while reset is held so every output reads 0 in reset
      alloc_req        = (state == S_ALLOC) && payload_rst_n;
      payload_in_ready = (state == S_WAIT_SOP) || (state == S_DATA);
      post_req         = (state == S_POST);
      case (state)
         S_ALLOC: begin
            if (alloc_ack) begin
               take_pointer = 1'b1;
               next_state   = S_WAIT_SOP;
            end
         end
         S_WAIT_SOP: begin
            if (accept && payload_in_start) begin
               latch_channel = 1'b1;
               next_state    = S_DATA;
            end
         end
         S_DATA: begin
            if (accept) begin
               if (payload_in_start) begin
                  // a fresh channel word restarts the packet in place
                  drop          = 1'b1;
                  latch_channel = 1'b1;
               end else if (sync_bad) begin
                  drop       = 1'b1;
                  next_state = S_WAIT_SOP;
               end else if (payload_in_end) begin
                  if (count == LAST_COUNT) begin
                     data_write = 1'b1;
                     next_state = S_PARAM;
                  end else begin
                     drop       = 1'b1;
                     next_state = S_WAIT_SOP;
                  end
               end else if (count == LAST_COUNT) begin
                  drop       = 1'b1;
                  next_state = S_WAIT_SOP;
               end else begin
                  data_write = 1'b1;
               end
            end
         end
         S_PARAM: next_state = S_POST;
         S_POST: begin
            if (post_ack) next_state = S_ALLOC;
         end
         default: next_state = S_ALLOC;
      endcase
   end

   assign post_pointer = buffer_pointer;

   always_ff @(posedge payload_clk) begin
      if (!payload_rst_n) begin
         state            <= S_ALLOC;
         count            <= '0;
         channel          <= '0;
         pid              <= '0;
         buffer_pointer   <= '0;
         buffer_write     <= 1'b0;
         buffer_address   <= '0;
         buffer_writedata <= '0;
         drop_count       <= '0;
      end else begin
         state        <= next_state;
         buffer_write <= 1'b0;
         if (take_pointer) buffer_pointer <= alloc_pointer;
         if (latch_channel) begin
            channel <= payload_in_data[15:0];
            count   <= '0;
         end
         if (data_write) begin
            buffer_write     <= 1'b1;
            buffer_address   <= P_BUFFER_ADDRESS_BITS'(count);
            buffer_writedata <= payload_in_data;
            count            <= count + 6'd1;
            if (count == 6'd0) pid <= payload_in_data[20:8];
         end
         if (state == S_PARAM) begin
            buffer_write     <= 1'b1;
            buffer_address   <= PARAM_ADDR;
            buffer_writedata <= pack_param(channel, pid);
         end
         if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_udp_ts_rx_dma.sv
// tb/tb_udp_ts_rx_dma.sv - scoreboard bench for udp_ts_rx_dma
module tb_udp_ts_rx_dma;
   logic        payload_clk = 1'b0;
   logic        payload_rst_n;
   logic        alloc_req;
   logic        alloc_ack;
   logic [1:0]  alloc_pointer;
   logic        payload_in_ready;
   logic        payload_in_valid;
   logic        payload_in_start;
   logic        payload_in_end;
   logic [31:0] payload_in_data;
   logic        buffer_write;
   logic [1:0]  buffer_pointer;
   logic [7:0]  buffer_address;
   logic [31:0] buffer_writedata;
   logic        post_req;
   logic [1:0]  post_pointer;
   logic        post_ack;
   logic [15:0] drop_count;

   udp_ts_rx_dma dut (
      .payload_clk(payload_clk), .payload_rst_n(payload_rst_n),
      .alloc_req(alloc_req), .alloc_ack(alloc_ack), .alloc_pointer(alloc_pointer),
      .payload_in_ready(payload_in_ready), .payload_in_valid(payload_in_valid),
      .payload_in_start(payload_in_start), .payload_in_end(payload_in_end),
      .payload_in_data(payload_in_data), .buffer_write(buffer_write),
      .buffer_pointer(buffer_pointer), .buffer_address(buffer_address),
      .buffer_writedata(buffer_writedata), .post_req(post_req),
      .post_pointer(post_pointer), .post_ack(post_ack), .drop_count(drop_count)
   );

   always #5 payload_clk = ~payload_clk;

   int total  = 0;
   int passed = 0;
   logic [41:0] wq[$];
   logic [1:0]  pq[$];
   logic [1:0]  grant_ptr = 2'd1;
   int          post_delay = 0;
   logic [1:0]  cur_ptr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // scoreboard monitor
   always @(negedge payload_clk) begin
      logic [41:0] e;
      if (buffer_write) begin
         if (wq.size() == 0) begin
            total++;
            $display("FAIL unexpected_write: got ptr %0d addr %0d data %h expected none",
                     buffer_pointer, buffer_address, buffer_writedata);
         end else begin
            e = wq.pop_front();
            chk("write", {buffer_pointer, buffer_address, buffer_writedata}, 64'(e));
         end
      end
      if (post_req) chk("ready_in_post", 64'(payload_in_ready), 64'd0);
      if (post_req && post_ack) begin
         if (pq.size() == 0) begin
            total++;
            $display("FAIL unexpected_post: got ptr %0d expected none", post_pointer);
         end else chk("post_pointer", 64'(post_pointer), 64'(pq.pop_front()));
      end
   end

   initial begin
      alloc_ack = 1'b0;
      alloc_pointer = 2'd0;
      forever begin
         @(posedge payload_clk); #1;
         alloc_ack = 1'b0;
         if (alloc_req) begin
            alloc_ack     = 1'b1;
            alloc_pointer = grant_ptr;
         end
      end
   end

   initial begin
      int waited = 0;
      post_ack = 1'b0;
      forever begin
         @(posedge payload_clk); #1;
         post_ack = 1'b0;
         if (post_req) begin
            if (waited >= post_delay) begin
               post_ack = 1'b1;
               waited = 0;
            end else waited++;
         end
      end
   end

   function automatic logic [31:0] word_at(input int i, input logic [15:0] ch);
      logic [7:0] idx;
      idx = 8'(i);
      return {8'hB0, ch[7:0], idx, 8'h5A};
   endfunction

   task automatic send_beat(input logic s, input logic e, input logic [31:0] d);
      int   guard = 0;
      logic acc;
      payload_in_valid = 1'b1;
      payload_in_start = s;
      payload_in_end   = e;
      payload_in_data  = d;
      do begin
         @(negedge payload_clk);
         acc = payload_in_ready;
         @(posedge payload_clk); #1;
         guard++;
      end while (!acc && guard < 300);
      if (!acc) begin
         total++;
         $display("FAIL beat_timeout: got no ready in %0d cycles expected ready", guard);
      end
      payload_in_valid = 1'b0;
   endtask

   task automatic idle();
      payload_in_valid = 1'b0;
      @(posedge payload_clk); #1;
   endtask

   task automatic push_write(input logic [1:0] p, input logic [7:0] a, input logic [31:0] d);
      wq.push_back({p, a, d});
   endtask

   task automatic send_packet(input logic [15:0] ch, input logic [31:0] first, input logic [1:0] p,
                              input bit with_start, input bit gap, input logic [31:0] exp_param);
      logic [31:0] d;
      if (with_start) send_beat(1'b1, 1'b0, {16'h0000, ch});
      for (int i = 0; i < 47; i++) begin
         d = (i == 0) ? first : word_at(i, ch);
         push_write(p, 8'(i), d);
         send_beat(1'b0, i == 46, d);
         if (gap) idle();
      end
      push_write(p, 8'd50, exp_param);
      pq.push_back(p);
   endtask

   task automatic wait_idle(input string name);
      int g = 0;
      while ((wq.size() != 0 || pq.size() != 0) && g < 3000) begin
         @(posedge payload_clk);
         g++;
      end
      chk(name, 64'(g < 3000), 64'd1);
      repeat (3) @(posedge payload_clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      payload_rst_n = 1'b0;
      payload_in_valid = 1'b0;
      payload_in_start = 1'b0;
      payload_in_end = 1'b0;
      payload_in_data = '0;
      repeat (3) @(posedge payload_clk);
      @(negedge payload_clk);
      chk("rst_alloc_req", 64'(alloc_req), 64'd0);
      chk("rst_ready", 64'(payload_in_ready), 64'd0);
      chk("rst_write", 64'(buffer_write), 64'd0);
      chk("rst_post_req", 64'(post_req), 64'd0);
      chk("rst_drop", 64'(drop_count), 64'd0);
      chk("rst_ptr", 64'(buffer_pointer), 64'd0);
      @(posedge payload_clk); #1;
      payload_rst_n = 1'b1;

      // good packet into pointer 1
      send_packet(16'h0005, 32'h4700_1110, 2'd1, 1'b1, 1'b0, 32'h0005_0011);
      grant_ptr = 2'd2;
      wait_idle("drain_good");

      // end on data beat 30 -> drop, pointer 2 retained
      send_beat(1'b1, 1'b0, 32'h0000_0006);
      for (int i = 0; i < 30; i++) begin
         d = word_at(i, 16'h0006);
         push_write(2'd2, 8'(i), d);
         send_beat(1'b0, 1'b0, d);
      end
      send_beat(1'b0, 1'b1, word_at(30, 16'h0006));
      grant_ptr = 2'd3;
      wait_idle("drain_early_end");
      chk("drop_early_end", 64'(drop_count), 64'd1);
      chk("ptr_kept", 64'(buffer_pointer), 64'd2);
      send_packet(16'h0009, 32'h4701_2345, 2'd2, 1'b1, 1'b0, 32'h0009_0123);
      wait_idle("drain_retry");

      // start reasserted at beat 10
      send_beat(1'b1, 1'b0, 32'h0000_0003);
      for (int i = 0; i < 10; i++) begin
         d = word_at(i, 16'h0003);
         push_write(2'd3, 8'(i), d);
         send_beat(1'b0, 1'b0, d);
      end
      send_beat(1'b1, 1'b0, 32'h0000_0007);
      send_packet(16'h0007, 32'h4710_00FF, 2'd3, 1'b0, 1'b0, 32'h0007_1000);
      grant_ptr = 2'd0;
      wait_idle("drain_restart");
      chk("drop_restart", 64'(drop_count), 64'd2);

      // valid toggling, slow post_ack
      post_delay = 20;
      send_packet(16'h1234, 32'h471F_FF00, 2'd0, 1'b1, 1'b1, 32'h1234_1FFF);
      grant_ptr = 2'd1;
      wait_idle("drain_toggle");
      post_delay = 0;

      // bad sync byte
`ifdef RX_SYNC_CHECK_EN
      send_beat(1'b1, 1'b0, 32'h0000_0002);
      for (int i = 0; i < 47; i++)
         send_beat(1'b0, i == 46, (i == 0) ? 32'h4800_0000 : word_at(i, 16'h0002));
      wait_idle("drain_sync");
      chk("drop_sync", 64'(drop_count), 64'd3);
      cur_ptr = 2'd1;
`else
      send_packet(16'h0002, 32'h4800_0000, 2'd1, 1'b1, 1'b0, 32'h0002_0000);
      grant_ptr = 2'd2;
      wait_idle("drain_sync");
      chk("drop_sync", 64'(drop_count), 64'd2);
      cur_ptr = 2'd2;
`endif

      // reset during data beat 20
      send_beat(1'b1, 1'b0, 32'h0000_000A);
      for (int i = 0; i < 20; i++) begin
         d = word_at(i, 16'h000A);
         push_write(cur_ptr, 8'(i), d);
         send_beat(1'b0, 1'b0, d);
      end
      payload_in_valid = 1'b1;
      payload_in_data  = word_at(20, 16'h000A);
      payload_rst_n    = 1'b0;
      @(posedge payload_clk);
      @(negedge payload_clk);
      chk("mid_rst_alloc_req", 64'(alloc_req), 64'd0);
      chk("mid_rst_ready", 64'(payload_in_ready), 64'd0);
      chk("mid_rst_write", 64'(buffer_write), 64'd0);
      chk("mid_rst_addr", 64'(buffer_address), 64'd0);
      chk("mid_rst_wdata", 64'(buffer_writedata), 64'd0);
      chk("mid_rst_post", 64'(post_req), 64'd0);
      chk("mid_rst_post_ptr", 64'(post_pointer), 64'd0);
      chk("mid_rst_drop", 64'(drop_count), 64'd0);
      @(posedge payload_clk); #1;
      payload_in_valid = 1'b0;
      payload_rst_n    = 1'b1;
      @(negedge payload_clk);
      chk("post_rst_alloc_req", 64'(alloc_req), 64'd1);
      chk("post_rst_ready", 64'(payload_in_ready), 64'd0);
      repeat (4) @(posedge payload_clk);
      chk("queues_empty", 64'(wq.size() + pq.size()), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
